// File: rtl/board_filler.sv
// Fills a ROWS x COLS board of colour codes, one cell per clock, from a seedable
// 16-bit Galois LFSR, optionally rejecting colours that would complete a run of three.
module board_filler #(
    parameter int          ROWS       = 8,
    parameter int          COLS       = 8,
    parameter int          CW         = 3,
    parameter int          NUM_COLORS = 5,
    parameter bit          NO_MATCH   = 1'b1,
    parameter logic [15:0] SEED_INIT  = 16'hACE1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     fresh,
    input  logic                     seed_load,
    input  logic [15:0]              seed,
    output logic [ROWS*COLS*CW-1:0]  new_board,
    output logic                     if_generated,
    output logic                     busy
);

    localparam int BW  = ROWS * COLS * CW;
    localparam int RW  = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int CLW = (COLS > 1) ? $clog2(COLS) : 1;

    typedef enum logic {IDLE, FILL} state_t;

    state_t         state, state_next;
    logic [15:0]    lfsr, lfsr_step;
    logic [RW-1:0]  row;
    logic [CLW-1:0] col;
    logic [BW-1:0]  work, work_next;
    logic [CW-1:0]  c0, c1, c2, color;
    logic [CW-1:0]  left1, left2, up1, up2;
    logic           h_pair, v_pair, bad0, bad1;
    logic           last_cell;
    int             cell_idx;

    function automatic logic [CW-1:0] wrap_inc(input logic [CW-1:0] c);
        return (c == CW'(NUM_COLORS)) ? CW'(1) : c + CW'(1);
    endfunction

    assign lfsr_step = lfsr[0] ? ((lfsr >> 1) ^ 16'hB400) : (lfsr >> 1);
    assign busy      = (state == FILL);
    assign last_cell = (row == RW'(ROWS - 1)) && (col == CLW'(COLS - 1));

    // Neighbours are read from the work board: only cells already written in this fill.
    always_comb begin
        cell_idx = int'(row) * COLS + int'(col);
        left1    = '0;
        left2    = '0;
        up1      = '0;
        up2      = '0;
        if (int'(col) >= 2) begin
            left1 = work[(cell_idx - 1) * CW +: CW];
            left2 = work[(cell_idx - 2) * CW +: CW];
        end
        if (int'(row) >= 2) begin
            up1 = work[(cell_idx - COLS) * CW +: CW];
            up2 = work[(cell_idx - 2 * COLS) * CW +: CW];
        end
    end

    always_comb begin
        c0     = CW'((lfsr[7:0] % 8'(NUM_COLORS)) + 8'd1);
        c1     = wrap_inc(c0);
        c2     = wrap_inc(c1);
        h_pair = (int'(col) >= 2) && (left1 == left2);
        v_pair = (int'(row) >= 2) && (up1 == up2);
        bad0   = (h_pair && (left1 == c0)) || (v_pair && (up1 == c0));
        bad1   = (h_pair && (left1 == c1)) || (v_pair && (up1 == c1));
        if (!NO_MATCH || !bad0) color = c0;
        else if (!bad1)         color = c1;
        else                    color = c2;
        work_next = work;
        work_next[cell_idx * CW +: CW] = color;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (fresh) state_next = FILL;
            FILL:    if (last_cell) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            // NOTE: the board registers are cleared on reset so a fill aborted by
            // reset can never leak into new_board; they are flops, not a RAM.
            lfsr         <= SEED_INIT;
            state        <= IDLE;
            row          <= '0;
            col          <= '0;
            work         <= '0;
            new_board    <= '0;
            if_generated <= 1'b0;
        end else begin
            if (seed_load) lfsr <= (seed == 16'h0000) ? SEED_INIT : seed;
            else           lfsr <= lfsr_step;
            state        <= state_next;
            if_generated <= 1'b0;
            case (state)
                IDLE: begin
                    row <= '0;
                    col <= '0;
                end
                FILL: begin
                    work <= work_next;
                    if (last_cell) begin
                        new_board    <= work_next;
                        if_generated <= 1'b1;
                        row          <= '0;
                        col          <= '0;
                    end else if (col == CLW'(COLS - 1)) begin
                        col <= '0;
                        row <= row + RW'(1);
                    end else begin
                        col <= col + CLW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_board_filler.sv
// Self-checking bench for board_filler: a default 8x8 instance and a 4x6, 3-colour
// instance, compared against an array-based board model and a rule checker.
module tb_board_filler;

    logic         clk = 1'b0;
    logic         rst;
    logic         fresh, seed_load;
    logic [15:0]  seed;
    logic [191:0] new_board;
    logic         if_generated, busy;

    logic         fresh_b, seed_load_b;
    logic [15:0]  seed_b;
    logic [71:0]  new_board_b;
    logic         if_generated_b, busy_b;

    logic [15:0]  m_lfsr, mb_lfsr;
    int           n_checks = 0;
    int           n_fail   = 0;

    always #5 clk = ~clk;

    board_filler dut (
        .clk(clk), .rst(rst), .fresh(fresh), .seed_load(seed_load), .seed(seed),
        .new_board(new_board), .if_generated(if_generated), .busy(busy)
    );

    board_filler #(.ROWS(4), .COLS(6), .CW(3), .NUM_COLORS(3)) dut_b (
        .clk(clk), .rst(rst), .fresh(fresh_b), .seed_load(seed_load_b), .seed(seed_b),
        .new_board(new_board_b), .if_generated(if_generated_b), .busy(busy_b)
    );

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // Reference LFSRs: one step per clock, seed_load wins, zero seed replaced.
    always @(posedge clk) begin
        if (rst) begin
            m_lfsr  <= 16'hACE1;
            mb_lfsr <= 16'hACE1;
        end else begin
            m_lfsr  <= seed_load   ? ((seed   == 16'h0) ? 16'hACE1 : seed)   : lstep(m_lfsr);
            mb_lfsr <= seed_load_b ? ((seed_b == 16'h0) ? 16'hACE1 : seed_b) : lstep(mb_lfsr);
        end
    end

    function automatic bit is_bad(input int b[8][8], input int r, input int c, input int v);
        bit bad = 1'b0;
        if (c >= 2) if (b[r][c-1] == v && b[r][c-2] == v) bad = 1'b1;
        if (r >= 2) if (b[r-1][c] == v && b[r-2][c] == v) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [191:0] model_board(input logic [15:0] start, input int rows,
                                                 input int cols, input int nc);
        int           b[8][8];
        int           cand;
        logic [15:0]  l = start;
        logic [191:0] res = '0;
        for (int r = 0; r < 8; r++) for (int c = 0; c < 8; c++) b[r][c] = 0;
        for (int r = 0; r < rows; r++) begin
            for (int c = 0; c < cols; c++) begin
                cand = int'(l[7:0]) % nc + 1;
                for (int t = 0; t < 2; t++)
                    if (is_bad(b, r, c, cand)) cand = cand % nc + 1;
                b[r][c] = cand;
                res[(r*cols + c)*3 +: 3] = 3'(cand);
                l = lstep(l);
            end
        end
        return res;
    endfunction

    function automatic int count_violations(input logic [191:0] bd, input int rows,
                                            input int cols, input int nc);
        int b[8][8];
        int n = 0;
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                b[r][c] = int'(bd[(r*cols + c)*3 +: 3]);
                if (b[r][c] < 1 || b[r][c] > nc) n++;
            end
        for (int r = 0; r < rows; r++)
            for (int c = 0; c < cols; c++) begin
                if (c >= 2 && b[r][c] == b[r][c-1] && b[r][c] == b[r][c-2]) n++;
                if (r >= 2 && b[r][c] == b[r-1][c] && b[r][c] == b[r-2][c]) n++;
            end
        return n;
    endfunction

    task automatic do_fill(input bit ld, input logic [15:0] sd, output logic [191:0] exp,
                           output int busy_cnt, output bit done);
        @(negedge clk);
        seed_load = ld; seed = sd; fresh = 1'b1;
        @(negedge clk);
        seed_load = 1'b0; fresh = 1'b0;
        exp = model_board(m_lfsr, 8, 8, 5);
        busy_cnt = 0; done = 1'b0;
        for (int i = 0; i < 200 && !done; i++) begin
            if (busy) busy_cnt++;
            if (if_generated) done = 1'b1;
            else @(negedge clk);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; fresh = 1'b0; seed_load = 1'b0; seed = '0;
        fresh_b = 1'b0; seed_load_b = 1'b0; seed_b = '0;
        repeat (2) @(negedge clk);
        n_checks++;
        if (new_board !== '0) begin n_fail++; $display("FAIL reset_board: got %h expected 0", new_board); end
        n_checks++;
        if (busy !== 1'b0 || if_generated !== 1'b0) begin
            n_fail++; $display("FAIL reset_flags: busy=%b gen=%b expected 0/0", busy, if_generated);
        end
        n_checks++;
        if (dut.lfsr !== 16'hACE1) begin n_fail++; $display("FAIL reset_lfsr: got %h expected ace1", dut.lfsr); end
        rst = 1'b0;
    endtask

    task automatic test_repeatable;
        logic [191:0] exp, first;
        int bc; bit done;
        do_fill(1'b1, 16'h1234, exp, bc, done);
        n_checks++;
        if (!done || bc != 64) begin n_fail++; $display("FAIL fill_busy: done=%b busy_cycles=%0d expected 1/64", done, bc); end
        n_checks++;
        if (new_board !== exp) begin n_fail++; $display("FAIL fill_board: got %h expected %h", new_board, exp); end
        first = new_board;
        @(negedge clk);
        n_checks++;
        if (if_generated !== 1'b0) begin n_fail++; $display("FAIL pulse_width: gen=%b expected 0", if_generated); end
        do_fill(1'b1, 16'h1234, exp, bc, done);
        n_checks++;
        if (!done || new_board !== first) begin n_fail++; $display("FAIL reseed_repeat: got %h expected %h", new_board, first); end
    endtask

    task automatic test_random_seeds;
        logic [191:0] exp;
        int bc, errs = 0, viol = 0; bit done;
        for (int k = 0; k < 200; k++) begin
            do_fill(1'b1, 16'($urandom_range(1, 65535)), exp, bc, done);
            if (!done || new_board !== exp) errs++;
            viol += count_violations(new_board, 8, 8, 5);
        end
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL random_boards: %0d of 200 boards differ from model, expected 0", errs); end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL random_rules: %0d range/triple violations, expected 0", viol); end
    endtask

    task automatic test_zero_seed;
        logic [191:0] exp, ref_board;
        int bc; bit done;
        do_fill(1'b1, 16'hACE1, exp, bc, done);
        ref_board = new_board;
        do_fill(1'b1, 16'h0000, exp, bc, done);
        n_checks++;
        if (!done || new_board !== ref_board) begin n_fail++; $display("FAIL zero_seed_same: got %h expected %h", new_board, ref_board); end
        n_checks++;
        if (new_board !== model_board(16'hACE1, 8, 8, 5)) begin
            n_fail++; $display("FAIL zero_seed_model: got %h expected %h", new_board, model_board(16'hACE1, 8, 8, 5));
        end
    endtask

    task automatic test_abort_and_ignore;
        int pulses = 0;
        @(negedge clk); fresh = 1'b1;
        @(negedge clk); fresh = 1'b0;
        repeat (30) @(negedge clk);
        rst = 1'b1;
        @(negedge clk); rst = 1'b0;
        n_checks++;
        if (busy !== 1'b0 || new_board !== '0 || if_generated !== 1'b0) begin
            n_fail++; $display("FAIL abort: busy=%b gen=%b board=%h expected 0/0/0", busy, if_generated, new_board);
        end
        repeat (80) @(negedge clk);
        n_checks++;
        if (new_board !== '0) begin n_fail++; $display("FAIL abort_publish: got %h expected 0", new_board); end
        fresh = 1'b1;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (i == 20) fresh = 1'b0;
            if (if_generated) pulses++;
        end
        n_checks++;
        if (pulses != 1) begin n_fail++; $display("FAIL ignore_fresh: %0d pulses expected 1", pulses); end
    endtask

    task automatic test_back_to_back;
        logic [191:0] exp = '0;
        int stamp[3];
        int pulses = 0, bad = 0;
        bit prev_busy = 1'b0;
        @(negedge clk); fresh = 1'b1;
        for (int cyc = 0; cyc < 400 && pulses < 3; cyc++) begin
            @(negedge clk);
            if (busy && !prev_busy) exp = model_board(m_lfsr, 8, 8, 5);
            prev_busy = busy;
            if (if_generated) begin
                if (new_board !== exp) bad++;
                stamp[pulses] = cyc;
                pulses++;
                if (pulses == 3) fresh = 1'b0;
            end
        end
        fresh = 1'b0;
        n_checks++;
        if (pulses != 3) begin n_fail++; $display("FAIL b2b_pulses: %0d pulses expected 3", pulses); end
        else begin
            n_checks++;
            if (stamp[1] - stamp[0] != 65 || stamp[2] - stamp[1] != 65) begin
                n_fail++; $display("FAIL b2b_period: got %0d,%0d expected 65,65", stamp[1]-stamp[0], stamp[2]-stamp[1]);
            end
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL b2b_boards: %0d boards differ from model, expected 0", bad); end
    endtask

    task automatic test_small_board;
        logic [71:0] exp;
        int bc, errs = 0, viol = 0, bcerr = 0; bit done;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            seed_load_b = 1'b1; seed_b = 16'($urandom_range(1, 65535)); fresh_b = 1'b1;
            @(negedge clk);
            seed_load_b = 1'b0; fresh_b = 1'b0;
            exp = 72'(model_board(mb_lfsr, 4, 6, 3));
            bc = 0; done = 1'b0;
            for (int i = 0; i < 100 && !done; i++) begin
                if (busy_b) bc++;
                if (if_generated_b) done = 1'b1;
                else @(negedge clk);
            end
            if (!done || bc != 24) bcerr++;
            if (new_board_b !== exp) errs++;
            viol += count_violations({120'h0, new_board_b}, 4, 6, 3);
        end
        n_checks++;
        if (bcerr != 0) begin n_fail++; $display("FAIL small_latency: %0d fills not 24 busy cycles, expected 0", bcerr); end
        n_checks++;
        if (errs != 0) begin n_fail++; $display("FAIL small_boards: %0d boards differ from model, expected 0", errs); end
        n_checks++;
        if (viol != 0) begin n_fail++; $display("FAIL small_rules: %0d violations, expected 0", viol); end
    endtask

    initial begin
        test_reset;
        test_repeatable;
        test_random_seeds;
        test_zero_seed;
        test_abort_and_ignore;
        test_back_to_back;
        test_small_board;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
